// File: rtl/fft_bf_sequencer.sv
// ---------------------------------------------------------------------------
// fft_bf_sequencer
//   Control and address generator for an in-place radix-2 DIT FFT built
//   around a single butterfly. Each stage issues one operand pair per cycle
//   (sample RAM addresses plus twiddle ROM index). The same addresses are
//   replayed D = RD_LAT + BF_LATENCY cycles later as write-back strobes.
//   The sequencer drains between stages so a stage never reads a location
//   whose write-back is still in flight.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   i_start      start request, honoured only in IDLE
//   o_busy       high from first issue cycle through last write-back
//   o_done       one-cycle pulse after the last write-back
//   o_stage      current stage index
//   o_rd_en      read strobe for sample RAM and twiddle ROM
//   o_rd_addr_a  upper-wing operand address
//   o_rd_addr_b  lower-wing operand address
//   o_tw_addr    twiddle ROM index
//   o_wr_en      write-back strobe, aligned to butterfly outputs
//   o_wr_addr_a  destination address for the upper-wing result
//   o_wr_addr_b  destination address for the lower-wing result
// ---------------------------------------------------------------------------
module fft_bf_sequencer #(
    parameter int N_LOG2     = 3,
    parameter int RD_LAT     = 1,
    parameter int BF_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [3:0]        o_stage,
    output logic              o_rd_en,
    output logic [N_LOG2-1:0] o_rd_addr_a,
    output logic [N_LOG2-1:0] o_rd_addr_b,
    output logic [N_LOG2-2:0] o_tw_addr,
    output logic              o_wr_en,
    output logic [N_LOG2-1:0] o_wr_addr_a,
    output logic [N_LOG2-1:0] o_wr_addr_b
);

    localparam int D  = RD_LAT + BF_LATENCY;
    localparam int AW = N_LOG2;
    localparam int KW = N_LOG2 - 1;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [3:0]      stage_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_a_q;
    logic [AW-1:0]   rd_b_q;
    logic [KW-1:0]   tw_q;

    logic            pipe_en_q [D];
    logic [AW-1:0]   pipe_a_q  [D];
    logic [AW-1:0]   pipe_b_q  [D];

    // Upper-wing address: a zero bit inserted into k at bit position s.
    function automatic logic [AW-1:0] addr_a_f(input logic [3:0] s, input logic [KW-1:0] k);
        logic [AW-1:0] kk;
        logic [AW-1:0] lo;
        kk = AW'(k);
        lo = kk & ((AW'(1) << s) - AW'(1));
        return ((kk >> s) << (s + 4'd1)) | lo;
    endfunction

    function automatic logic [AW-1:0] addr_b_f(input logic [3:0] s, input logic [KW-1:0] k);
        return addr_a_f(s, k) + (AW'(1) << s);
    endfunction

    function automatic logic [KW-1:0] tw_f(input logic [3:0] s, input logic [KW-1:0] k);
        logic [KW-1:0] pos;
        pos = k & ((KW'(1) << s) - KW'(1));
        return pos << (4'(N_LOG2 - 1) - s);
    endfunction

    // Output registers are loaded with the values for the state being
    // entered, so rd_en rises the cycle after i_start is sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        state_q <= ISSUE;
                        stage_q <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= addr_a_f(4'd0, '0);
                        rd_b_q  <= addr_b_f(4'd0, '0);
                        tw_q    <= tw_f(4'd0, '0);
                    end
                end
                ISSUE: begin
                    if (k_q == '1) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        rd_en_q <= 1'b0;
                        rd_a_q  <= '0;
                        rd_b_q  <= '0;
                        tw_q    <= '0;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= addr_a_f(stage_q, k_q + 1'b1);
                        rd_b_q  <= addr_b_f(stage_q, k_q + 1'b1);
                        tw_q    <= tw_f(stage_q, k_q + 1'b1);
                    end
                end
                DRAIN: begin
                    // Leave after D cycles: the last write-back of this stage
                    // is on the outputs during the final DRAIN cycle.
                    if (cnt_q == CW'(D - 1)) begin
                        if (stage_q == 4'(N_LOG2 - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            stage_q <= stage_q + 4'd1;
                            k_q     <= '0;
                            rd_en_q <= 1'b1;
                            rd_a_q  <= addr_a_f(stage_q + 4'd1, '0);
                            rd_b_q  <= addr_b_f(stage_q + 4'd1, '0);
                            tw_q    <= tw_f(stage_q + 4'd1, '0);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    stage_q <= '0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-back replay: the issued read addresses delayed by exactly D cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < D; i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            pipe_en_q[0] <= rd_en_q;
            pipe_a_q[0]  <= rd_a_q;
            pipe_b_q[0]  <= rd_b_q;
            for (int unsigned i = 1; i < D; i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a_q[i]  <= pipe_a_q[i-1];
                pipe_b_q[i]  <= pipe_b_q[i-1];
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_stage     = stage_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr_a = rd_a_q;
    assign o_rd_addr_b = rd_b_q;
    assign o_tw_addr   = tw_q;
    assign o_wr_en     = pipe_en_q[D-1];
    assign o_wr_addr_a = pipe_a_q[D-1];
    assign o_wr_addr_b = pipe_b_q[D-1];

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_bf_sequencer
//   Scoreboard bench for two sequencer configurations: N_LOG2=3/D=4 and
//   N_LOG2=4/D=5. Stimulus pushes the expected read, write and done events
//   (with their cycle numbers) into queues; a negedge monitor pops and
//   compares whenever a DUT strobe is seen, and flags events that never came.
// ---------------------------------------------------------------------------
module tb_fft_bf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: N=8, D=4
    logic       a_rst, a_start, a_busy, a_done, a_rd_en, a_wr_en;
    logic [3:0] a_stage;
    logic [2:0] a_ra, a_rb, a_wa, a_wb;
    logic [1:0] a_tw;
    // DUT B: N=16, D=5
    logic       b_rst, b_start, b_busy, b_done, b_rd_en, b_wr_en;
    logic [3:0] b_stage;
    logic [3:0] b_ra, b_rb, b_wa, b_wb;
    logic [2:0] b_tw;

    fft_bf_sequencer #(.N_LOG2(3), .RD_LAT(1), .BF_LATENCY(3)) dut_a (
        .clk(clk), .rst(a_rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
        .o_stage(a_stage), .o_rd_en(a_rd_en), .o_rd_addr_a(a_ra), .o_rd_addr_b(a_rb),
        .o_tw_addr(a_tw), .o_wr_en(a_wr_en), .o_wr_addr_a(a_wa), .o_wr_addr_b(a_wb)
    );

    fft_bf_sequencer #(.N_LOG2(4), .RD_LAT(2), .BF_LATENCY(3)) dut_b (
        .clk(clk), .rst(b_rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .o_stage(b_stage), .o_rd_en(b_rd_en), .o_rd_addr_a(b_ra), .o_rd_addr_b(b_rb),
        .o_tw_addr(b_tw), .o_wr_en(b_wr_en), .o_wr_addr_a(b_wa), .o_wr_addr_b(b_wb)
    );

    typedef struct { int cyc; int st; int a; int b; int tw; } ev_t;
    typedef struct { int t; int lim; int len; } run_t;

    // queues: 0 rdA, 1 wrA, 2 doneA, 3 rdB, 4 wrB, 5 doneB
    ev_t  evq [6][$];
    run_t runs[2][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt_rd[2] = '{0, 0};
    int   cnt_wr[2] = '{0, 0};

    // Hand-computed N=8 schedule (stage 0, 1, 2; k = 0..3 each)
    int ta8 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tb8 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int ttw8[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic exp_busy(input int d);
        for (int i = 0; i < runs[d].size(); i++) begin
            int hi;
            hi = runs[d][i].t + runs[d][i].len;
            if (runs[d][i].lim < hi) hi = runs[d][i].lim;
            if (cyc >= runs[d][i].t + 1 && cyc <= hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input int qi, input int c, input int st, input int a, input int b, input int tw);
        ev_t e;
        e.cyc = c; e.st = st; e.a = a; e.b = b; e.tw = tw;
        evq[qi].push_back(e);
    endtask

    task automatic handle(input int qi, input logic en, input int st, input int a,
                          input int b, input int tw, input string nm);
        ev_t e;
        while (evq[qi].size() > 0 && evq[qi][0].cyc < cyc) begin
            e = evq[qi].pop_front();
            n_cmp++; n_bad++;
            $display("FAIL %s missing event: actual=none expected cyc=%0d a=%0d b=%0d",
                     nm, e.cyc, e.a, e.b);
        end
        if (en) begin
            if (evq[qi].size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL %s unexpected strobe cyc=%0d actual a=%0d b=%0d expected none",
                         nm, cyc, a, b);
            end else begin
                e = evq[qi].pop_front();
                check({nm, "_cyc"}, cyc, e.cyc);
                if (e.st >= 0) check({nm, "_stage"}, st, e.st);
                check({nm, "_a"}, a, e.a);
                check({nm, "_b"}, b, e.b);
                check({nm, "_tw"}, tw, e.tw);
            end
        end
    endtask

    always @(negedge clk) begin
        handle(0, a_rd_en, int'(a_stage), int'(a_ra), int'(a_rb), int'(a_tw), "rdA");
        handle(1, a_wr_en, -1, int'(a_wa), int'(a_wb), 0, "wrA");
        handle(2, a_done, -1, 0, 0, 0, "doneA");
        handle(3, b_rd_en, int'(b_stage), int'(b_ra), int'(b_rb), int'(b_tw), "rdB");
        handle(4, b_wr_en, -1, int'(b_wa), int'(b_wb), 0, "wrB");
        handle(5, b_done, -1, 0, 0, 0, "doneB");
        check("busyA", int'(a_busy), int'(exp_busy(0)));
        check("busyB", int'(b_busy), int'(exp_busy(1)));
        if (a_rd_en) cnt_rd[0]++;
        if (a_wr_en) cnt_wr[0]++;
        if (b_rd_en) cnt_rd[1]++;
        if (b_wr_en) cnt_wr[1]++;
    end

    // Expected N=8 run starting at cycle t; events after lim are dropped (reset).
    task automatic push8(input int t, input int lim);
        run_t r;
        for (int j = 0; j < 12; j++) begin
            int rc;
            rc = t + 1 + (j / 4) * 8 + (j % 4);
            if (rc <= lim)     push(0, rc, j / 4, ta8[j], tb8[j], ttw8[j]);
            if (rc + 4 <= lim) push(1, rc + 4, -1, ta8[j], tb8[j], 0);
        end
        if (t + 25 <= lim) push(2, t + 25, -1, 0, 0, 0);
        r.t = t; r.lim = lim; r.len = 24;
        runs[0].push_back(r);
    endtask

    // Expected N=16 run: groups of 2*span, twiddle step N/(2*span).
    task automatic push16(input int t);
        run_t r;
        for (int s = 0; s < 4; s++) begin
            int span;
            span = 1 << s;
            for (int g = 0; g < 8 / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    int k, a, rc;
                    k  = g * span + p;
                    a  = g * 2 * span + p;
                    rc = t + 1 + s * 13 + k;
                    push(3, rc, s, a, a + span, p * (16 / (2 * span)));
                    push(4, rc + 5, -1, a, a + span, 0);
                end
            end
        end
        push(5, t + 53, -1, 0, 0, 0);
        r.t = t; r.lim = 1 << 30; r.len = 52;
        runs[1].push_back(r);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic zero_a(input string nm);
        check({nm, "_busy"}, int'(a_busy), 0);
        check({nm, "_done"}, int'(a_done), 0);
        check({nm, "_stage"}, int'(a_stage), 0);
        check({nm, "_rd_en"}, int'(a_rd_en), 0);
        check({nm, "_rd_addr"}, int'({a_ra, a_rb, a_tw}), 0);
        check({nm, "_wr_en"}, int'(a_wr_en), 0);
        check({nm, "_wr_addr"}, int'({a_wa, a_wb}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        a_rst = 1'b0; b_rst = 1'b0; a_start = 1'b1; b_start = 1'b1;

        // Reset held with i_start high: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            zero_a("rstA");
            check("rstB_busy", int'(b_busy), 0);
            check("rstB_rd_en", int'(b_rd_en), 0);
            check("rstB_wr_en", int'(b_wr_en), 0);
        end
        @(posedge clk); #1;
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        wait_cyc(cyc + 5);
        @(negedge clk);
        zero_a("idleA");

        // Full N=8 run, with a stray start pulse at T+10.
        @(posedge clk); #1;
        t = cyc;
        push8(t, 1 << 30);
        cnt_rd[0] = 0; cnt_wr[0] = 0;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_cyc(t + 10);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_cyc(t + 32);
        check("pulsesA_rd", cnt_rd[0], 12);
        check("pulsesA_wr", cnt_wr[0], 12);

        // Reset in the middle of stage 1.
        @(posedge clk); #1;
        t = cyc;
        push8(t, t + 14);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_cyc(t + 14);
        a_rst = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b1;
        @(negedge clk);
        zero_a("midrstA");
        wait_cyc(t + 40);

        // Restart with i_start held: a second run begins right after DONE.
        @(posedge clk); #1;
        t = cyc;
        push8(t, 1 << 30);
        push8(t + 26, 1 << 30);
        cnt_rd[0] = 0; cnt_wr[0] = 0;
        a_start = 1'b1;
        wait_cyc(t + 27);
        a_start = 1'b0;
        wait_cyc(t + 26 + 32);
        check("pulsesA2_rd", cnt_rd[0], 24);
        check("pulsesA2_wr", cnt_wr[0], 24);

        // N=16, D=5 run.
        @(posedge clk); #1;
        t = cyc;
        push16(t);
        cnt_rd[1] = 0; cnt_wr[1] = 0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        wait_cyc(t + 60);
        check("pulsesB_rd", cnt_rd[1], 32);
        check("pulsesB_wr", cnt_wr[1], 32);

        for (int q = 0; q < 6; q++) check("queue_leftover", evq[q].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
